// File: rtl/xadc_multi_channel_monitor.sv
// Scans NUM_CH XADC auxiliary channels over the DRP once per sample period,
// box-car averages 2^AVG_LOG2 scans per channel and latches saturation.
module xadc_multi_channel_monitor #(
    parameter int                     NUM_CH     = 2,
    parameter logic [7*NUM_CH-1:0]    CH_ADDR    = {7'h1E, 7'h16},
    parameter int                     SAMPLE_DIV = 10000000,
    parameter int                     AVG_LOG2   = 2,
    parameter logic [15:0]            SAT_LIMIT  = 16'hFFD0,
    parameter int                     TIMEOUT    = 64
) (
    input  logic                     CLK100MHZ,
    input  logic                     rst,
    input  logic                     enable,
    output logic [6:0]               drp_daddr,
    output logic                     drp_den,
    input  logic [15:0]              drp_do,
    input  logic                     drp_drdy,
    output logic [12*NUM_CH-1:0]     ch_data,
    output logic [NUM_CH-1:0]        ch_sat,
    output logic                     data_valid,
    output logic                     overrun,
    output logic                     drp_err
);

    localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int DIV_W  = $clog2(SAMPLE_DIV);
    localparam int TO_W   = $clog2(TIMEOUT + 1);
    localparam int ACC_W  = 12 + AVG_LOG2;
    localparam int SCAN_W = AVG_LOG2 + 1;

    localparam logic [CH_W-1:0]   LAST_CH   = CH_W'(NUM_CH - 1);
    localparam logic [DIV_W-1:0]  LAST_TICK = DIV_W'(SAMPLE_DIV - 1);
    localparam logic [TO_W-1:0]   LAST_WAIT = TO_W'(TIMEOUT - 1);
    localparam logic [SCAN_W-1:0] LAST_SCAN = SCAN_W'((1 << AVG_LOG2) - 1);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_WAIT  = 3'd2,
        ST_ACC   = 3'd3,
        ST_NEXT  = 3'd4
    } state_t;

    state_t              state_r;
    logic [CH_W-1:0]     ch_r;
    logic [DIV_W-1:0]    tick_cnt_r;
    logic [TO_W-1:0]     wait_cnt_r;
    logic [15:0]         sample_r;
    logic [ACC_W-1:0]    acc_r [NUM_CH];
    logic [NUM_CH-1:0]   sat_r;
    logic [SCAN_W-1:0]   scan_cnt_r;
    logic                tick_s;
    logic [11:0]         code_s;
    logic                sat_s;

    // Saturated raw words are pinned to full scale before averaging.
    function automatic logic [11:0] sample_code(input logic [15:0] raw);
        if (raw > SAT_LIMIT) begin
            return 12'hFFF;
        end else begin
            return raw[15:4];
        end
    endfunction

    // Per-sample code and saturation flag derived from the captured DRP word.
    always_comb begin
        code_s = sample_code(sample_r);
        sat_s  = (sample_r > SAT_LIMIT);
    end

    assign tick_s = enable && (tick_cnt_r == LAST_TICK);

    // Sample-period counter; parked at zero while scanning is disabled.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            tick_cnt_r <= '0;
        end else if (!enable || (tick_cnt_r == LAST_TICK)) begin
            tick_cnt_r <= '0;
        end else begin
            tick_cnt_r <= tick_cnt_r + DIV_W'(1);
        end
    end

    // Scan sequencer, accumulators and all registered outputs.
    always_ff @(posedge CLK100MHZ or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            ch_r       <= '0;
            wait_cnt_r <= '0;
            sample_r   <= 16'h0000;
            sat_r      <= '0;
            scan_cnt_r <= '0;
            drp_daddr  <= CH_ADDR[6:0];
            drp_den    <= 1'b0;
            ch_data    <= '0;
            ch_sat     <= '0;
            data_valid <= 1'b0;
            overrun    <= 1'b0;
            drp_err    <= 1'b0;
            for (int i = 0; i < NUM_CH; i++) begin
                acc_r[i] <= '0;
            end
        end else begin
            drp_den    <= 1'b0;
            data_valid <= 1'b0;
            // A tick during an active scan is dropped, never queued.
            if (tick_s && (state_r != ST_IDLE)) begin
                overrun <= 1'b1;
            end
            case (state_r)
                ST_IDLE: begin
                    if (tick_s) begin
                        ch_r      <= '0;
                        drp_daddr <= CH_ADDR[6:0];
                        drp_den   <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end
                end
                ST_ISSUE: begin
                    wait_cnt_r <= '0;
                    state_r    <= ST_WAIT;
                end
                ST_WAIT: begin
                    if (drp_drdy) begin
                        sample_r <= drp_do;
                        state_r  <= ST_ACC;
                    end else if (wait_cnt_r == LAST_WAIT) begin
                        sample_r <= 16'h0000;
                        drp_err  <= 1'b1;
                        state_r  <= ST_ACC;
                    end else begin
                        wait_cnt_r <= wait_cnt_r + TO_W'(1);
                    end
                end
                ST_ACC: begin
                    acc_r[ch_r] <= acc_r[ch_r] + ACC_W'(code_s);
                    if (sat_s) begin
                        sat_r[ch_r] <= 1'b1;
                    end
                    state_r <= ST_NEXT;
                end
                ST_NEXT: begin
                    if (ch_r != LAST_CH) begin
                        ch_r      <= ch_r + CH_W'(1);
                        drp_daddr <= CH_ADDR[7*(int'(ch_r)+1) +: 7];
                        drp_den   <= 1'b1;
                        state_r   <= ST_ISSUE;
                    end else begin
                        state_r <= ST_IDLE;
                        // A full window is published even if enable just fell;
                        // only a partial window is thrown away.
                        if (scan_cnt_r == LAST_SCAN) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                ch_data[12*i +: 12] <= acc_r[i][AVG_LOG2 +: 12];
                                acc_r[i]            <= '0;
                            end
                            ch_sat     <= sat_r;
                            sat_r      <= '0;
                            scan_cnt_r <= '0;
                            data_valid <= 1'b1;
                        end else if (!enable) begin
                            for (int i = 0; i < NUM_CH; i++) begin
                                acc_r[i] <= '0;
                            end
                            sat_r      <= '0;
                            scan_cnt_r <= '0;
                        end else begin
                            scan_cnt_r <= scan_cnt_r + SCAN_W'(1);
                        end
                    end
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/xadc_multi_channel_monitor.md
Name: xadc_multi_channel_monitor

Overview:
Parametrised successor to the single-purpose XADC current-sense reader. Sequences DRP reads over NUM_CH auxiliary channels once per sample period, box-car averages 2^AVG_LOG2 scans per channel, and flags saturation. Sits between the xadc_wiz DRP port and the display and motor-control logic. Publishes raw 12-bit averaged codes; decimal conversion stays downstream.

Parameters:
NUM_CH, 2, number of channels scanned, 1..8
CH_ADDR, {7'h1E,7'h16}, packed DRP addresses, channel i at bits [7i+6:7i]
SAMPLE_DIV, 10000000, CLK100MHZ cycles between scan starts, >= 2
AVG_LOG2, 2, log2 of scans averaged per published result, 0..4
SAT_LIMIT, 16'hFFD0, raw DRP word above which a sample counts as saturated
TIMEOUT, 64, cycles to wait for drdy before abandoning a read

Ports:
CLK100MHZ  in  1  system clock
rst  in  1  asynchronous active-high reset
enable  in  1  level; scans start only while high
drp_daddr  out  7  DRP address to xadc_wiz daddr_in
drp_den  out  1  one-cycle DRP read strobe
drp_do  in  16  DRP read data, ADC code in [15:4]
drp_drdy  in  1  DRP data-ready
ch_data  out  12*NUM_CH  averaged code, channel i at [12i+11:12i]
ch_sat  out  NUM_CH  channel saw a saturated sample in the last window
data_valid  out  1  one-cycle pulse when ch_data/ch_sat update
overrun  out  1  sticky: tick arrived while a scan was active
drp_err  out  1  sticky: a DRP read timed out

Behaviour:
- Reset (async assert, sync use after release): all outputs 0, drp_daddr = CH_ADDR[6:0], FSM IDLE, tick counter, accumulators, scan count and sat latches cleared. Sticky flags clear only on rst.
- Tick counter: free-running 0..SAMPLE_DIV-1 while enable=1, held at 0 while enable=0; tick = one-cycle pulse at wrap.
- FSM states: IDLE, ISSUE, WAIT, ACC, NEXT.
- IDLE: on tick -> ISSUE with ch index 0. Tick while not IDLE sets overrun; the tick is dropped, no queued scan.
- ISSUE: drp_daddr = CH_ADDR[ch]; drp_den=1 for exactly this cycle; -> WAIT. drp_daddr held stable from ISSUE until leaving WAIT.
- WAIT: drp_drdy=1 -> capture drp_do, -> ACC. No drdy within TIMEOUT cycles -> sample = 0, drp_err=1, -> ACC. drdy in the same cycle as den is ignored.
- ACC (one cycle): code = (drp_do > SAT_LIMIT) ? 12'hFFF : drp_do[15:4]; a saturated sample sets sat_latch[ch]. acc[ch] += code; acc width 12+AVG_LOG2, cannot overflow.
- NEXT: if ch < NUM_CH-1 then ch+1, -> ISSUE; else scan_cnt+1, -> IDLE. When scan_cnt reaches 2^AVG_LOG2: ch_data[i] = acc[i] >> AVG_LOG2 (truncate), ch_sat = sat_latch, data_valid=1 for that cycle; acc, sat_latch, scan_cnt cleared in the same cycle.
- Latency per channel: ISSUE + WAIT(n) + ACC + NEXT = n+3 cycles. Scan start = tick cycle +1.
- enable falling mid-scan: the scan completes and accumulates normally. On returning to IDLE with enable=0, the partial window (acc, sat_latch, scan_cnt) is discarded and outputs hold.
- AVG_LOG2=0: publish after every scan.

Test Plan:
- Reset mid-WAIT (NUM_CH=2, SAMPLE_DIV=100): assert rst with den outstanding -> den=0, ch_data=0, flags=0, daddr=7'h16 immediately; the next scan starts 100 cycles after release.
- Averaging (AVG_LOG2=2): DRP model returns ch0 codes 0x100,0x102,0x104,0x106 and ch1 constant 0x800 with drdy 3 cycles after den -> single data_valid after the 4th scan, ch0=0x103, ch1=0x800, ch_sat=0; daddr alternates 0x16/0x1E.
- Saturation: ch1 returns 16'hFFE0 in one scan of the window and 16'h8000 in the others -> ch1=(0xFFF+3*0x800)>>2=0x9FF, ch_sat=2'b10; the next clean window gives ch_sat=2'b00.
- Timeout: model withholds drdy for ch0 -> after 64 cycles drp_err=1, sample taken as 0, scan proceeds to ch1, drp_err stays 1 until rst.
- Overrun: SAMPLE_DIV=4, drdy latency 10 -> overrun=1, no back-to-back scans, the scan in progress is unaffected.
- Enable drop: deassert enable during the 2nd scan of 4 -> that scan finishes, no data_valid, ch_data holds; on re-enable the first publish comes after 4 full new scans.
